// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART transmit-side arbiter.
//   DEFAULT_DATA_W : default byte width (matches uart_tx data_in)
//   MAX_REQ        : largest requester count the helpers support
//   arb_state_t    : arbiter FSM states
//   rr_pick()      : round-robin pick over a requester valid vector
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int MAX_REQ        = 8;
    localparam int MAX_IDW        = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } arb_state_t;

    // First set bit of valid, searching ptr, ptr+1, ... modulo num_req.
    // Returns ptr when nothing is valid; callers gate with |valid.
    function automatic logic [MAX_IDW-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IDW-1:0] ptr,
        input int                 num_req
    );
        logic [MAX_IDW:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            // ptr < num_req and k < num_req, so one conditional subtract
            // is enough to wrap.
            idx = {1'b0, ptr} + (MAX_IDW + 1)'(k);
            if (idx >= (MAX_IDW + 1)'(num_req)) begin
                idx = idx - (MAX_IDW + 1)'(num_req);
            end
            if (!found && (k < num_req) && valid[idx[MAX_IDW-1:0]]) begin
                rr_pick = idx[MAX_IDW-1:0];
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// rr_select
// Combinational round-robin selector: priority encoder over valid, rotated
// so that the search starts at ptr.
//   valid     in  NUM_REQ  request vector
//   ptr       in  IDW      highest-priority index this cycle
//   idx       out IDW      selected index (meaningful when any_valid)
//   any_valid out 1        at least one request present
// ----------------------------------------------------------------------------
module rr_select
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     idx,
    output logic               any_valid
);

    always_comb begin
        idx       = IDW'(rr_pick(MAX_REQ'(valid), MAX_IDW'(ptr), NUM_REQ));
        any_valid = |valid;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one uart_tx between NUM_REQ byte producers with round-robin grants.
// A granted byte is latched, presented to uart_tx with start held until busy
// is seen, and no further grant is made until uart_tx reports done.
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_data  per-requester byte handshake (data packed by index)
//   req_ready           one-cycle one-hot accept pulse
//   tx_start/tx_data    to uart_tx
//   tx_busy/tx_done     from uart_tx
//   grant_id            requester owning the transmitter
//   active              FSM not in IDLE
//   err_timeout         one-cycle pulse when a byte is dropped (no busy seen)
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int START_TIMEOUT = 64,
    parameter int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    input  logic                      tx_done,
    output logic [IDW-1:0]            grant_id,
    output logic                      active,
    output logic                      err_timeout
);

    localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

    arb_state_t          state_q, state_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [IDW-1:0]      grant_id_q, grant_id_d;
    logic                active_q, active_d;
    logic                err_timeout_q, err_timeout_d;

    logic [IDW-1:0]      sel_idx;
    logic                sel_any;
    logic [IDW-1:0]      next_ptr;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_select (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .idx       (sel_idx),
        .any_valid (sel_any)
    );

    // Priority moves to the requester after the one just served.
    assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        req_ready_d   = '0;
        err_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_any) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (sel_idx == IDW'(i)) begin
                            tx_data_d = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    grant_id_d  = sel_idx;
                    req_ready_d = NUM_REQ'(1) << sel_idx;
                    tx_start_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // busy has priority over a coinciding timeout
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
                    tx_start_d    = 1'b0;
                    err_timeout_d = 1'b1;
                    ptr_d         = next_ptr;
                    state_d       = IDLE;
                end
            end
            WAIT_DONE: begin
                tx_start_d = 1'b0;
                if (tx_done) begin
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: every register, data included, is reset so that outputs are
        // fully defined right after reset; a mid-frame reset drops the byte.
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ready_q   <= '0;
            grant_id_q    <= '0;
            active_q      <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together
            // from the values computed in the combinational block.
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ready_q   <= req_ready_d;
            grant_id_q    <= grant_id_d;
            active_q      <= active_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_id_q;
    assign active      = active_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one uart_tx instance between NUM_REQ byte producers.
- Each requester has a valid/ready byte handshake.
- The arbiter latches the granted byte and drives uart_tx start/data_in. It then holds off further grants until uart_tx reports done.
- Sits between the system's byte sources and the uart_tx/baud_gen pair, and runs on the same clock and reset.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 1..8).
- DATA_W, 8, byte width; must match uart_tx data_in.
- START_TIMEOUT, 64, max cycles in ISSUE waiting for tx_busy before aborting the byte (must be >= 2 x baud divider).
- IDW, $clog2(NUM_REQ) with a minimum of 1, width of grant_id.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte-valid; held with data until that requester's req_ready pulse
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte from that requester accepted
- tx_start  out  1  to uart_tx start
- tx_data  out  DATA_W  to uart_tx data_in
- tx_busy  in  1  from uart_tx busy
- tx_done  in  1  from uart_tx done (one-cycle pulse)
- grant_id  out  IDW  index of the requester currently owning the transmitter
- active  out  1  high whenever the state is not IDLE
- err_timeout  out  1  one-cycle pulse when a byte is aborted

Behaviour:
- All outputs are registered. Reset state: IDLE, rr pointer=0, timeout counter=0, tx_start=0, tx_data=0, req_ready=0, grant_id=0, active=0, err_timeout=0.
- Reset mid-operation returns to IDLE immediately and the in-flight byte is discarded. uart_tx shares the reset, so no abort handshake is needed.
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE, no req_valid bit set: stay in IDLE.
- IDLE, any req_valid bit set:
  - g = first set bit searching ptr, ptr+1, ... modulo NUM_REQ.
  - On that edge: latch tx_data=req_data[g], grant_id=g, req_ready=one-hot(g), tx_start=1, counter=0, go to ISSUE.
  - Latency from valid to ready is 1 cycle. The requester may change valid/data the cycle after ready.
- ISSUE:
  - req_ready returns to 0 after its single cycle.
  - tx_start and tx_data are held constant.
  - The counter increments every cycle.
  - tx_busy=1: tx_start=0, go to WAIT_DONE.
  - Else if counter==START_TIMEOUT-1: tx_start=0, err_timeout pulses, ptr=g+1 mod NUM_REQ, go to IDLE. The byte is dropped; it was already acknowledged.
  - If tx_busy and the timeout coincide, busy wins.
- WAIT_DONE:
  - tx_start=0; tx_data is held.
  - req_valid is ignored; no new grant until done.
  - tx_done=1: ptr=g+1 mod NUM_REQ, go to IDLE.
  - tx_done is ignored in IDLE and ISSUE.
  - There is no timeout in WAIT_DONE; uart_tx is trusted to finish its frame.
- Throughput: the earliest next grant is in the cycle after tx_done. Bytes are back-to-back, with at most one idle cycle between uart_tx frames beyond uart_tx's own turnaround.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- NUM_REQ=1: ptr is constant 0 and behaviour degenerates to a simple byte-handshake front end.
- Simultaneous valid on multiple requesters in one cycle: exactly one req_ready bit is ever set.

Decomposition:
- Package uart_pkg:
  - DATA_W default constant.
  - Typedef enum arb_state_t {IDLE, ISSUE, WAIT_DONE}.
  - Function rr_pick(valid, ptr) returning the granted index.
- Sub-module rr_select (combinational: masked-priority encoder over req_valid rotated by ptr, outputs index and any_valid). It is reusable for a future RX-side demux/scheduler.
- The FSM, counter, ptr and output registers stay in uart_tx_arbiter.

Test Plan:
- Single byte, full chain: baud_gen BAUD_DIV=10, uart_tx, and uart_rx looped back. Requester 2 sends 0xAB. Required: req_ready[2] pulses once, 1 cycle after valid; grant_id=2; uart_rx data_out=0xAB with data_ready; err_timeout never asserts.
- Full contention: all 4 valid at once, with bytes 0x11, 0x22, 0x33, 0x44 at ptr=0. Required: receiver sees 0x11, 0x22, 0x33, 0x44 in order; each req_ready is one-hot and a single pulse; active is low only in the gaps.
- Rotation fairness: requester 1 streams 0xA0..0xA3 continuously while requester 3 streams 0xB0..0xB1. Required: order A0, B0, A1, B1, A2, A3.
- Timeout: tx_busy tied 0 by the stub, requester 0 sends 0x5A. Required: req_ready[0] pulses; tx_start stays high exactly START_TIMEOUT cycles; err_timeout pulses once; return to IDLE; the next grant starts from ptr=1.
- Reset mid-frame: assert reset for 1 cycle in WAIT_DONE while requester 1 is sending 0xC3. Required: all outputs are at their reset values the next cycle and ptr=0. Then requester 0 sends 0x3C and the receiver gets 0x3C cleanly.
- NUM_REQ=1 build: 3 back-to-back bytes 0x01, 0x02, 0x03. Required: all received in order, grant_id constant 0.
